// File: rtl/dca_matrix_lsu_arbiter.sv
// Round-robin arbiter sharing one matrix LSU among NUM_REQ instruction requesters; grant to lsu_inst_valid is 1 cycle.
// An LSU completion frees the slot after one IDLE cycle. Optional watchdog: DCA_MATRIX_LSU_ARB_TIMEOUT_EN.
`ifndef BW_DCA_MATRIX_LSU_INST
`define BW_DCA_MATRIX_LSU_INST 32
`endif

module dca_matrix_lsu_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int BW_LSU_INST    = `BW_DCA_MATRIX_LSU_INST,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           rstnn,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req_inst_valid,
  input  logic [NUM_REQ*BW_LSU_INST-1:0] req_inst_list,
  output logic [NUM_REQ-1:0]             req_inst_ready,
  output logic [NUM_REQ-1:0]             req_done,
  output logic                           lsu_inst_valid,
  output logic [BW_LSU_INST-1:0]         lsu_inst,
  input  logic                           lsu_inst_ready,
  output logic [NUM_REQ-1:0]             owner,
  output logic                           busy,
  output logic                           timeout_error
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("dca_matrix_lsu_arbiter: parameter out of range");
  end

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [RR_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [RR_W:0]       cand;
  logic [RR_W-1:0]     cand_idx;
  logic                grant_vld;
  logic [RR_W-1:0]     grant_idx;
  logic [NUM_REQ-1:0]  grant_oh;
  logic                grant_fire;
  logic                done_fire;

  // Scan offsets from high to low so the nearest valid requester above rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    cand_idx  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + (RR_W+1)'(i);
      if (cand >= (RR_W+1)'(NUM_REQ)) begin
        cand = cand - (RR_W+1)'(NUM_REQ);
      end
      cand_idx = cand[RR_W-1:0];
      if (req_inst_valid[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  assign grant_oh   = grant_vld ? (NUM_REQ'(1) << grant_idx) : '0;
  assign grant_fire = (state == IDLE) && enable && grant_vld;
  assign done_fire  = (state == ISSUE) && enable && lsu_inst_ready;

  // Gated by rstnn so no accept pulse leaks out while reset is held.
  assign req_inst_ready = (grant_fire && rstnn) ? grant_oh : '0;
  assign req_done       = done_fire ? owner : '0;
  assign lsu_inst_valid = (state == ISSUE);
  assign busy           = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (grant_fire) begin
          state_nxt  = ISSUE;
          rr_ptr_nxt = (grant_idx == RR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      ISSUE: begin
        if (done_fire) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lsu_inst <= '0;
      owner    <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      if (grant_fire) begin
        lsu_inst <= req_inst_list[grant_idx*BW_LSU_INST +: BW_LSU_INST];
        owner    <= grant_oh;
      end else if (done_fire) begin
        owner    <= '0;
      end
    end
  end

`ifdef DCA_MATRIX_LSU_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TO_W-1:0] to_cnt;
  logic            to_err;

  // Counter parks at the limit; the flag only clears on reset.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else if (grant_fire) begin
      to_cnt <= '0;
    end else if ((state == ISSUE) && enable && !lsu_inst_ready) begin
      if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        to_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign timeout_error = to_err;
`else
  assign timeout_error = 1'b0;
`endif

endmodule
